// File: rtl/arb_pkg.sv
// arb_pkg - shared definitions for the 8-way round-robin arbiter.
//   ARB_N_REQ   : number of requesters
//   ARB_IDX_W   : width of the encoded grant index
//   arb_state_t : arbiter FSM state encoding
package arb_pkg;

  localparam int ARB_N_REQ = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/onehot_to_idx_8.sv
// onehot_to_idx_8 - combinational 8-bit one-hot to 3-bit binary encoder.
// Ports:
//   onehot : in  [7:0]  one-hot (or all-zero) vector
//   idx    : out [2:0]  index of the set bit; 0 for an all-zero input
module onehot_to_idx_8
  import arb_pkg::*;
(
  input  logic [ARB_N_REQ-1:0] onehot,
  output logic [ARB_IDX_W-1:0] idx
);

  // OR-reduction of the indices of the set bits; exact for a one-hot input.
  always_comb begin
    idx = '0;
    for (int i = 0; i < ARB_N_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | ARB_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 - round-robin arbiter sharing one resource among 8 requesters.
// The owner keeps the grant until it drops its request; on release the next
// winner is granted on the same edge, with the released owner last in line.
// Optional build macro: ARB_HOLD_TIMEOUT_EN - limits a tenure to MAX_HOLD
// cycles whenever another requester is pending.
// Ports:
//   clk      : in   clock, rising edge
//   reset    : in   asynchronous active-high reset
//   req      : in   [7:0] request levels
//   gnt      : out  [7:0] registered one-hot grant
//   gntIdx   : out  [2:0] index of the current/last owner
//   gntValid : out  OR of gnt
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ARB_IDLE | no owner; any request is granted on the next edge
// ARB_BUSY | owner idx_q holds gnt until it releases (or times out)
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int N_REQ    = ARB_N_REQ,
  parameter int IDX_W    = ARB_IDX_W,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gntIdx,
  output logic             gntValid
);

  if (N_REQ != ARB_N_REQ || IDX_W != ARB_IDX_W) begin : g_bad_size
    $error("rr_arbiter_8 is built for 8 requesters and a 3-bit index only");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("rr_arbiter_8 MAX_HOLD must be within 2..256");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] enc_idx;
  logic [N_REQ-1:0] search_req;
  logic [IDX_W-1:0] search_ptr;
  logic [N_REQ-1:0] win_oh;
  logic             found;
  logic             release_own;
  logic             new_grant;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int               HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              force_rel;

  assign force_rel   = (state_q == ARB_BUSY) && (hold_q == HOLD_LAST) &&
                       (|(req & ~gnt_q));
  assign release_own = (state_q == ARB_BUSY) && (!req[idx_q] || force_rel);

  // Restart on every new grant, count while the owner holds, saturate at
  // the last cycle so a lone owner keeps the grant indefinitely.
  always_comb begin
    hold_d = hold_q;
    if (state_d == ARB_IDLE || new_grant) begin
      hold_d = '0;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign release_own = (state_q == ARB_BUSY) && !req[idx_q];
`endif

  // On release the search starts just past the owner, and the owner is
  // masked out so a forced release can never re-grant it.
  always_comb begin
    if (state_q == ARB_IDLE) begin
      search_req = req;
      search_ptr = ptr_q;
    end else begin
      search_req = req & ~gnt_q;
      search_ptr = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    logic [IDX_W-1:0] pos;
    win_oh = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = search_ptr + IDX_W'(k);
      if (!found && search_req[pos]) begin
        win_oh[pos] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          gnt_d   = win_oh;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (release_own) begin
          ptr_d   = search_ptr;
          gnt_d   = win_oh;
          state_d = found ? ARB_BUSY : ARB_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign new_grant = (|gnt_d) && (gnt_d != gnt_q);

  onehot_to_idx_8 u_enc (
    .onehot (gnt_d),
    .idx    (enc_idx)
  );

  // The index keeps naming the last owner while idle.
  assign idx_d = (|gnt_d) ? enc_idx : idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign gntIdx   = idx_q;
  assign gntValid = |gnt_q;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Round-robin arbiter sharing one resource among 8 requesters.
- Produces a registered one-hot grant and its 3-bit encoded index.
- The index is formed by a one-hot-to-binary encoder, so downstream muxes select the owner's data directly.
- Sits between request sources and a shared datapath/bus; the grant is held until the owner releases it.

Parameters:
N_REQ, 8, number of requesters; the block is built and verified for 8 only.
IDX_W, 3, width of the encoded grant index; equals log2(N_REQ).
MAX_HOLD, 16, maximum grant length in cycles when ARB_HOLD_TIMEOUT_EN is defined; legal range 2..256.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req  input  8  request vector; requester i holds req[i]=1 for as long as it needs the resource
gnt  output  8  registered one-hot grant; at most one bit set
gntIdx  output  3  binary index of the current/last owner
gntValid  output  1  1 while any gnt bit is set (OR of gnt)

Behaviour:
- Reset (asynchronous, effective immediately, mid-grant included):
  - gnt=0, gntIdx=0, gntValid=0, state IDLE.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
  - Hold counter=0.
- Priority search: first i with req[i]=1, scanning ptr, ptr+1, ... mod 8 with wrap from 7 to 0.
- States:
  - IDLE:
    - If req!=0, go to BUSY on the next edge, granting the search winner.
    - Latency is 1 cycle: req sampled at edge k, gnt visible after edge k.
    - If req==0, stay in IDLE.
  - BUSY, owner o, req[o]=1: hold gnt unchanged; ptr unchanged.
  - BUSY, req[o]=0 (release), sampled at an edge:
    - ptr <= o+1 mod 8.
    - Same edge: if any other req is set, grant the search winner from the new ptr (back-to-back, no idle bubble) and stay in BUSY.
    - Otherwise gnt<=0 and go to IDLE.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[i] is only set if req[i] was 1 at the granting edge.
  - gntValid == |gnt.
- gntIdx:
  - Updated on the same edge as gnt to the encoded owner index.
  - Retains the last owner while IDLE.
  - Meaningful to consumers only when gntValid=1.
- Simultaneous release and new requests: handled by the back-to-back rule; the just-released owner has lowest priority in the next search.
- A requester re-asserting req immediately after release waits its round-robin turn.
- Requests arriving while BUSY: ignored until release; no queuing beyond the req levels themselves.

Optional Feature:
ARB_HOLD_TIMEOUT_EN
- Defined:
  - Hold counter counts cycles in BUSY with the same owner; it resets to 0 on every new grant.
  - When counter==MAX_HOLD-1 and any other req is set, force release: treat as req[o]=0 (ptr<=o+1, grant next winner).
  - If no other requester is pending, the owner keeps the grant and the counter saturates at MAX_HOLD-1.
- Not defined: no counter logic; grants are held indefinitely until released.

Decomposition:
- Shared package arb_pkg:
  - Constants ARB_N_REQ=8 and ARB_IDX_W=3.
  - State enum type arb_state_t with values ARB_IDLE and ARB_BUSY.
- One natural sub-module: onehot_to_idx_8, a combinational 8-bit one-hot to 3-bit index encoder.
  - Output is 0 for the all-zero input.
  - Used to produce the next gntIdx from the next gnt.
- Search and rotation logic stay in rr_arbiter_8.

Test Plan:
- Reset then req=8'b0000_0100 -> after 1 edge gnt=8'b0000_0100, gntIdx=2, gntValid=1; after req drops, 1 edge later gnt=0, gntValid=0, gntIdx stays 2.
- From reset, req=8'hFF held; each owner drops req for 1 cycle after 3 cycles of grant -> grants rotate 0,1,2,...,7,0 with no idle cycle between owners.
- Owner 7 releases while req=8'b0000_0011 -> wrap: next gnt=8'b0000_0001 on the same edge, gntIdx=0.
- Assert reset asynchronously mid-grant (owner 5) between clock edges -> gnt=0, gntValid=0, gntIdx=0 immediately; after deassertion with req=8'b0010_0001, requester 0 is granted first.
- ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4: req[1] and req[3] held high continuously -> gnt alternates 1,3,1,... every 4 cycles; with req[1] alone, gnt[1] held indefinitely.
- Random req stimulus over 10k cycles -> check gnt one-hot-or-zero, gntIdx matches gnt when gntValid=1, and no requester waits more than 7 grant tenures.
